// File: rtl/cipher_pkg.sv
// Shared Polybius-sum cipher definitions: FSM encodings and the keyed square lookup,
// used by both the encrypt and decrypt stream blocks.
package cipher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_KEYS  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    typedef struct packed {
        logic       invalid;
        logic [7:0] code;
    } code_t;

    // Square keyed with "DANIEL": rows D A N I E / L B C F G / H K M O P / Q R S T U / V W X Y Z.
    // J shares the I cell; anything outside 'A'..'Z' yields code 0 and the invalid flag.
    function automatic code_t poly_lookup(input logic [7:0] ch);
        code_t r;
        r.invalid = 1'b0;
        r.code    = 8'd0;
        case (ch)
            "D": r.code = 8'd11;
            "A": r.code = 8'd12;
            "N": r.code = 8'd13;
            "I": r.code = 8'd14;
            "J": r.code = 8'd14;
            "E": r.code = 8'd15;
            "L": r.code = 8'd21;
            "B": r.code = 8'd22;
            "C": r.code = 8'd23;
            "F": r.code = 8'd24;
            "G": r.code = 8'd25;
            "H": r.code = 8'd31;
            "K": r.code = 8'd32;
            "M": r.code = 8'd33;
            "O": r.code = 8'd34;
            "P": r.code = 8'd35;
            "Q": r.code = 8'd41;
            "R": r.code = 8'd42;
            "S": r.code = 8'd43;
            "T": r.code = 8'd44;
            "U": r.code = 8'd45;
            "V": r.code = 8'd51;
            "W": r.code = 8'd52;
            "X": r.code = 8'd53;
            "Y": r.code = 8'd54;
            "Z": r.code = 8'd55;
            default: r.invalid = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/polybius_code.sv
// Combinational ASCII-to-Polybius code converter.
module polybius_code
    import cipher_pkg::*;
(
    input  logic [7:0] i_w_char,
    output logic [7:0] o_r_code,
    output logic       o_r_invalid
);

    code_t lookup;

    always_comb begin
        lookup      = poly_lookup(i_w_char);
        o_r_code    = lookup.code;
        o_r_invalid = lookup.invalid;
    end

endmodule

// File: rtl/encrypt_stream.sv
// Streaming Polybius-sum encryptor: converts the key once per message, then adds the
// repeating key code to each plaintext code with a one-deep output register.
module encrypt_stream
    import cipher_pkg::*;
#(
    parameter int p_secret_length = 6
) (
    input  logic                         i_w_clk,
    input  logic                         i_w_rst_n,
    input  logic [p_secret_length*8-1:0] i_w_secret,
    input  logic                         i_w_start,
    input  logic [7:0]                   i_w_data,
    input  logic                         i_w_valid,
    input  logic                         i_w_last,
    output logic                         o_r_ready,
    output logic [7:0]                   o_r_cipher,
    output logic                         o_r_valid,
    output logic                         o_r_last,
    input  logic                         i_w_ready,
    output logic                         o_r_busy,
    output logic                         o_r_error
);

    localparam int KW = (p_secret_length > 1) ? $clog2(p_secret_length) : 1;
    localparam logic [KW-1:0] KLAST = KW'(p_secret_length - 1);

    state_e state_q, state_d;
    logic [p_secret_length-1:0][7:0] secret_q, secret_d;
    logic [p_secret_length-1:0][7:0] codes_q, codes_d;
    logic [KW-1:0] kidx_q, kidx_d;
    logic [7:0]    cipher_q, cipher_d;
    logic          valid_q, valid_d, last_q, last_d, error_q, error_d;

    logic [7:0] lk_char, lk_code;
    logic       lk_inv, accept, handoff;

    // One converter is shared: key characters during KEYS, plaintext otherwise.
    // The first key character sits in the top byte, hence the reversed index.
    always_comb lk_char = (state_q == ST_KEYS) ? secret_q[KLAST - kidx_q] : i_w_data;

    polybius_code u_code (
        .i_w_char    (lk_char),
        .o_r_code    (lk_code),
        .o_r_invalid (lk_inv)
    );

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_w_start)              state_d = ST_KEYS;
            ST_KEYS:  if (kidx_q == KLAST)        state_d = ST_RUN;
            ST_RUN:   if (accept && i_w_last)     state_d = ST_FLUSH;
            ST_FLUSH: if (valid_q && i_w_ready)   state_d = ST_IDLE;
            default:                              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_r_ready = (state_q == ST_RUN) && (!valid_q || i_w_ready);
        o_r_busy  = (state_q != ST_IDLE);
        accept    = i_w_valid && o_r_ready;
        handoff   = valid_q && i_w_ready;
    end

    always_comb begin
        secret_d = secret_q;
        codes_d  = codes_q;
        kidx_d   = kidx_q;
        cipher_d = cipher_q;
        valid_d  = valid_q;
        last_d   = last_q;
        error_d  = error_q;
        if (state_q == ST_IDLE && i_w_start) begin
            secret_d = i_w_secret;
            error_d  = 1'b0;
            kidx_d   = '0;
        end
        if (state_q == ST_KEYS) begin
            codes_d[kidx_q] = lk_code;
            if (lk_inv) error_d = 1'b1;
            kidx_d = (kidx_q == KLAST) ? '0 : kidx_q + KW'(1);
        end
        if (handoff) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        // A new accept overrides the handoff clear so back-to-back bytes stream at full rate.
        if (accept) begin
            cipher_d = lk_code + codes_q[kidx_q];
            valid_d  = 1'b1;
            last_d   = i_w_last;
            if (lk_inv) error_d = 1'b1;
            kidx_d   = (kidx_q == KLAST) ? '0 : kidx_q + KW'(1);
        end
    end

    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            secret_q <= '0;
            codes_q  <= '0;
            kidx_q   <= '0;
            cipher_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            secret_q <= secret_d;
            codes_q  <= codes_d;
            kidx_q   <= kidx_d;
            cipher_q <= cipher_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            error_q  <= error_d;
        end
    end

    assign o_r_cipher = cipher_q;
    assign o_r_valid  = valid_q;
    assign o_r_last   = last_q;
    assign o_r_error  = error_q;

endmodule

// File: tb/tb_encrypt_stream.sv
// Directed bench for encrypt_stream: table-driven streaming plus stall, invalid-char,
// start-during-run, reset-mid-message and 2-character key wrap sequences.
module tb_encrypt_stream;

    logic        clk, rst_n;
    logic [47:0] secret;
    logic        start, valid, last, dready;
    logic [7:0]  data;
    logic        rdy, ovalid, olast, busy, error;
    logic [7:0]  cipher;

    logic [15:0] c2_secret;
    logic        c2_start, c2_valid, c2_last;
    logic [7:0]  c2_data;
    logic        c2_rdy, c2_ovalid, c2_olast, c2_busy, c2_error;
    logic [7:0]  c2_cipher;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] exp;
    } vec_t;
    vec_t vec[6];

    encrypt_stream #(.p_secret_length(6)) dut6 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_secret(secret), .i_w_start(start),
        .i_w_data(data), .i_w_valid(valid), .i_w_last(last), .o_r_ready(rdy),
        .o_r_cipher(cipher), .o_r_valid(ovalid), .o_r_last(olast), .i_w_ready(dready),
        .o_r_busy(busy), .o_r_error(error)
    );

    encrypt_stream #(.p_secret_length(2)) dut2 (
        .i_w_clk(clk), .i_w_rst_n(rst_n), .i_w_secret(c2_secret), .i_w_start(c2_start),
        .i_w_data(c2_data), .i_w_valid(c2_valid), .i_w_last(c2_last), .o_r_ready(c2_rdy),
        .o_r_cipher(c2_cipher), .o_r_valid(c2_ovalid), .o_r_last(c2_olast), .i_w_ready(1'b1),
        .o_r_busy(c2_busy), .o_r_error(c2_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start at a falling edge and returns at the first falling edge in RUN.
    task automatic start_msg(input logic [47:0] key);
        int cnt;
        cnt = 0;
        @(negedge clk);
        secret = key;
        start  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (rdy) break;
            cnt++;
        end
        chk("keys_cycles", cnt, 6);
    endtask

    // Streams vec[first..5] with downstream always ready, then checks return to IDLE.
    task automatic run_vec(input int first);
        for (int i = first; i < 6; i++) begin
            valid = 1'b1;
            data  = vec[i].data;
            last  = vec[i].last;
            @(negedge clk);
            chk($sformatf("cipher[%0d]", i), cipher, vec[i].exp);
            chk($sformatf("ovalid[%0d]", i), ovalid, 1);
            chk($sformatf("olast[%0d]", i), olast, vec[i].last);
        end
        valid = 1'b0;
        last  = 1'b0;
        @(negedge clk);
        chk("idle_valid", ovalid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        logic [7:0] exp2[4];
        exp2 = '{8'd23, 8'd24, 8'd23, 8'd24};
        vec[0] = '{"D", 1'b0, 8'd22};
        vec[1] = '{"A", 1'b0, 8'd24};
        vec[2] = '{"N", 1'b0, 8'd26};
        vec[3] = '{"I", 1'b0, 8'd28};
        vec[4] = '{"L", 1'b0, 8'd42};
        vec[5] = '{"A", 1'b1, 8'd24};

        rst_n = 1'b1; secret = '0; start = 0; valid = 0; last = 0; data = '0; dready = 1'b1;
        c2_secret = '0; c2_start = 0; c2_valid = 0; c2_last = 0; c2_data = '0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_cipher", cipher, 0);
        chk("rst_valid", ovalid, 0);
        chk("rst_last", olast, 0);
        chk("rst_ready", rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;

        // Plain DANILA/DANILA message at full rate.
        start_msg("DANILA");
        run_vec(0);
        chk("danila_error", error, 0);

        // Downstream stall for three cycles after the second byte.
        start_msg("DANILA");
        valid = 1'b1; data = "D"; last = 1'b0;
        @(negedge clk);
        chk("stall_d", cipher, 22);
        data = "A";
        @(negedge clk);
        chk("stall_a", cipher, 24);
        dready = 1'b0;
        data   = "N";
        #1 chk("stall_ready0", rdy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall_hold_cipher%0d", i), cipher, 24);
            chk($sformatf("stall_hold_valid%0d", i), ovalid, 1);
            chk($sformatf("stall_hold_ready%0d", i), rdy, 0);
        end
        dready = 1'b1;
        run_vec(2);

        // Invalid plaintext byte: cipher is the key code alone, error sticks until next start.
        start_msg("DANILA");
        valid = 1'b1; data = 8'h31; last = 1'b1;
        @(negedge clk);
        chk("inv_cipher", cipher, 11);
        chk("inv_error", error, 1);
        chk("inv_last", olast, 1);
        valid = 1'b0; last = 1'b0;
        @(negedge clk);
        chk("inv_idle_busy", busy, 0);
        chk("inv_idle_error", error, 1);
        start_msg("DANILA");
        chk("inv_cleared", error, 0);
        run_vec(0);

        // Start pulse with a different key during RUN must be ignored.
        start_msg("DANILA");
        valid = 1'b1; data = "D"; last = 1'b0;
        @(negedge clk);
        chk("ign_d", cipher, 22);
        start = 1'b1; secret = "ZZZZZZ"; data = "A";
        @(negedge clk);
        start = 1'b0;
        chk("ign_a", cipher, 24);
        chk("ign_ready", rdy, 1);
        run_vec(2);

        // Reset mid-message, then a clean repeat of the first message.
        start_msg("DANILA");
        valid = 1'b1; data = "D"; last = 1'b0;
        @(negedge clk);
        data = "A";
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cipher", cipher, 0);
        chk("mid_rst_valid", ovalid, 0);
        chk("mid_rst_ready", rdy, 0);
        chk("mid_rst_busy", busy, 0);
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_msg("DANILA");
        run_vec(0);

        // Two-character key wraps every other byte.
        @(negedge clk);
        c2_secret = "DA";
        c2_start  = 1'b1;
        begin
            int cnt;
            cnt = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                c2_start = 1'b0;
                if (c2_rdy) break;
                cnt++;
            end
            chk("c2_keys_cycles", cnt, 2);
        end
        for (int i = 0; i < 4; i++) begin
            c2_valid = 1'b1;
            c2_data  = "A";
            c2_last  = (i == 3);
            @(negedge clk);
            chk($sformatf("c2_cipher[%0d]", i), c2_cipher, exp2[i]);
            chk($sformatf("c2_valid[%0d]", i), c2_ovalid, 1);
        end
        chk("c2_last", c2_olast, 1);
        c2_valid = 1'b0; c2_last = 1'b0;
        @(negedge clk);
        chk("c2_idle", c2_busy, 0);
        chk("c2_error", c2_error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/encrypt_stream.md
ENCRYPT_STREAM -- requirements
Module: encrypt_stream

Interface
REQ-001 SHALL have parameter p_secret_length, default 6, number of ASCII characters in the secret key.
REQ-002 SHALL have port i_w_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_w_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_w_secret  input  p_secret_length*8  key string, first character in most significant byte.
REQ-005 SHALL have port i_w_start  input  1  begins a message; sampled only in IDLE.
REQ-006 SHALL have ports i_w_data  input  8  plaintext ASCII byte; i_w_valid  input  1; i_w_last  input  1  final byte of message; o_r_ready  output  1.
REQ-007 SHALL have ports o_r_cipher  output  8  cipher byte; o_r_valid  output  1; o_r_last  output  1; i_w_ready  input  1  downstream accept.
REQ-008 SHALL have ports o_r_busy  output  1  not IDLE; o_r_error  output  1  sticky invalid-character flag.

Function
REQ-009 SHALL implement the forward (encrypt) direction of the team's Polybius-sum cipher: o_r_cipher = code(plain) + code(key[k]), 8-bit unsigned, no overflow possible (max 55+55=110).
REQ-010 SHALL map characters through the shared Polybius table (codes 11..55, row*10+col); J maps to I's code; fixed values include D=11, A=12, N=13, I=14, L=21.
REQ-011 SHALL treat any byte outside 'A'..'Z' (plaintext or key) as invalid: code 0 used, o_r_error set and held until the next accepted start.
REQ-012 SHALL use FSM states IDLE, KEYS, RUN, FLUSH.
REQ-013 IDLE: on i_w_start=1 latch i_w_secret, clear o_r_error and key index, go to KEYS; i_w_start outside IDLE SHALL be ignored.
REQ-014 KEYS: convert one key character per cycle into a code register array, exactly p_secret_length cycles, then RUN; o_r_ready=0 throughout.
REQ-015 RUN: o_r_ready = !o_r_valid || i_w_ready; a byte is accepted when i_w_valid && o_r_ready.
REQ-016 Accepted byte SHALL appear on o_r_cipher with o_r_valid=1 on the next cycle (latency 1), o_r_last = accepted i_w_last.
REQ-017 Key index SHALL advance by one per accepted byte and wrap from p_secret_length-1 to 0; SHALL not advance on stalled cycles.
REQ-018 o_r_cipher/o_r_valid/o_r_last SHALL hold stable while o_r_valid && !i_w_ready.
REQ-019 Simultaneous output handoff and new accept in one cycle SHALL sustain one byte per cycle.
REQ-020 Accepting a byte with i_w_last=1 SHALL move to FLUSH; FLUSH SHALL return to IDLE on the cycle the last byte is taken (o_r_valid && i_w_ready).

Reset
REQ-021 Asserting i_w_rst_n=0, at any time including mid-message, SHALL force IDLE, o_r_valid=0, o_r_last=0, o_r_cipher=0, o_r_ready=0, o_r_busy=0, o_r_error=0, key index 0.
REQ-022 Latched key and code array SHALL reset to 0; no output byte in flight survives reset.

Structure
REQ-023 The Polybius table, code-lookup function and FSM state encodings SHALL live in shared package cipher_pkg, also used by decrypt.
REQ-024 One sub-module polybius_code (8-bit ASCII in, 8-bit code + invalid flag out, combinational) SHALL be instantiated for plaintext and reused for key conversion.

Verification
REQ-025 Key "DANILA", plaintext "DANILA" with last on 'A', i_w_ready=1 -> cipher 22,24,26,28,42,24, o_r_last on the 6th, o_r_error=0, then IDLE.
REQ-026 p_secret_length=2, key "DA", plaintext "AAAA" -> 23,24,23,24 (key wrap).
REQ-027 i_w_ready=0 for 3 cycles mid-message -> o_r_cipher held, o_r_ready=0, no byte lost or duplicated, key index unchanged.
REQ-028 Plaintext byte '1' (0x31) -> cipher equals key code only, o_r_error=1 until next start.
REQ-029 i_w_rst_n pulsed low during RUN -> all outputs 0 immediately; following start with key "DANILA" reproduces REQ-025 exactly.
REQ-030 i_w_start pulsed during RUN -> ignored; key index and stream unaffected.
